// File: rtl/fifo_drain_pkg.sv
// Shared state encoding and line levels for the FIFO-to-UART drain.
// FIFO_DRAIN_PARITY_EN adds an even-parity bit to every frame.
package fifo_drain_pkg;

   localparam int unsigned STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_POP    = 3'd1;
   localparam state_t ST_LOAD   = 3'd2;
   localparam state_t ST_START  = 3'd3;
   localparam state_t ST_DATA   = 3'd4;
   localparam state_t ST_PARITY = 3'd5;
   localparam state_t ST_STOP   = 3'd6;

   localparam int unsigned DEF_DATA_W = 4;
`ifdef FIFO_DRAIN_PARITY_EN
   localparam int unsigned FRAME_BITS = DEF_DATA_W + 3;
`else
   localparam int unsigned FRAME_BITS = DEF_DATA_W + 2;
`endif

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/bit_tick_gen.sv
// Baud counter: tick_c marks the last clk of each serial bit; tick_next_c
// predicts it one cycle early so registered outputs can line up with it.
module bit_tick_gen #(
   parameter int unsigned CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick_c,
   output logic tick_next_c
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_c      = (cnt_q == LAST_CNT);
   assign tick_next_c = (cnt_d == LAST_CNT);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear || tick_c) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx_drain.sv
// Pops FIFO entries and serializes each as start, data LSB-first, stop.
// Define FIFO_DRAIN_PARITY_EN to insert an even-parity bit after the data.
module fifo_uart_tx_drain
   import fifo_drain_pkg::*;
#(
   parameter int unsigned DATA_W       = 4,
   parameter int unsigned CLKS_PER_BIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

   state_t               state_q, state_d;
   logic [DATA_W-1:0]    shift_q, shift_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 tx_q, tx_d;
   logic                 rd_en_q, rd_en_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 tick_c, tick_next_c, clear_c;
`ifdef FIFO_DRAIN_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   // Counter is held at zero until the frame starts, so START begins at count 0.
   assign clear_c = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_LOAD);

   bit_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tick (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear_c),
      .tick_c      (tick_c),
      .tick_next_c (tick_next_c)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
`ifdef FIFO_DRAIN_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         ST_IDLE:  if (en && !fifo_empty) state_d = ST_POP;
         ST_POP:   state_d = ST_LOAD;
         ST_LOAD: begin
            shift_d   = fifo_rd_data;
            bit_cnt_d = '0;
`ifdef FIFO_DRAIN_PARITY_EN
            parity_d  = ^fifo_rd_data;
`endif
            state_d   = ST_START;
         end
         ST_START: if (tick_c) state_d = ST_DATA;
         ST_DATA: begin
            if (tick_c) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
`ifdef FIFO_DRAIN_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
`ifdef FIFO_DRAIN_PARITY_EN
         ST_PARITY: if (tick_c) state_d = ST_STOP;
`endif
         ST_STOP:  if (tick_c) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so the registers line up with state_q.
      case (state_d)
         ST_START:  tx_d = START_LEVEL;
         ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_DRAIN_PARITY_EN
         ST_PARITY: tx_d = parity_d;
`endif
         default:   tx_d = IDLE_LEVEL;
      endcase
      rd_en_d = (state_d == ST_POP);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_STOP) && tick_next_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= IDLE_LEVEL;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef FIFO_DRAIN_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   assign tx         = tx_q;
   assign fifo_rd_en = rd_en_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
